// File: rtl/vartheta_seq_ctrl.sv
// Iterative SWAN128 vartheta sequencer: one 64-bit vartheta layer is time-shared
// between the L and R halves of the state for a per-block number of passes.

module vartheta #(
    parameter int SIDE_SIZE   = 64,
    parameter int COLUMN_SIZE = SIDE_SIZE / 4,
    parameter int PA          = 1,
    parameter int PB          = 3,
    parameter int PC          = 13
) (
    input  logic [0:SIDE_SIZE-1] x_i,
    output logic [0:SIDE_SIZE-1] y_o
);
    // Rotate toward higher bit index, i.e. a numeric right rotation of the column.
    function automatic logic [COLUMN_SIZE-1:0] rotr(input logic [COLUMN_SIZE-1:0] v, input int r);
        logic [2*COLUMN_SIZE-1:0] dbl;
        dbl = {v, v} >> (r % COLUMN_SIZE);
        return dbl[COLUMN_SIZE-1:0];
    endfunction

    assign y_o = {rotr(x_i[0 +: COLUMN_SIZE], PC),
                  rotr(x_i[COLUMN_SIZE +: COLUMN_SIZE], PB),
                  rotr(x_i[2*COLUMN_SIZE +: COLUMN_SIZE], PA),
                  x_i[3*COLUMN_SIZE +: COLUMN_SIZE]};
endmodule

module vartheta_seq_ctrl #(
    parameter int BLOCK_SIZE  = 128,
    parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
    parameter int COLUMN_SIZE = SIDE_SIZE / 4,
    parameter int PA          = 1,
    parameter int PB          = 3,
    parameter int PC          = 13,
    parameter int ITER_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:BLOCK_SIZE-1] in_block,
    input  logic [ITER_W-1:0]     in_iter,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:BLOCK_SIZE-1] out_block,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, DONE} state_t;

    state_t                state_q;
    logic [ITER_W-1:0]     cnt_q;
    logic [ITER_W-1:0]     cnt_d;
    logic [0:SIDE_SIZE-1]  l_q;
    logic [0:SIDE_SIZE-1]  r_q;
    logic [0:SIDE_SIZE-1]  vt_op;
    logic [0:SIDE_SIZE-1]  vt_res;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;

    // The single vartheta sees R only while in RIGHT, L otherwise.
    assign vt_op = (state_q == RIGHT) ? r_q : l_q;
    assign cnt_d = cnt_q - ITER_W'(1);

    vartheta #(
        .SIDE_SIZE  (SIDE_SIZE),
        .COLUMN_SIZE(COLUMN_SIZE),
        .PA         (PA),
        .PB         (PB),
        .PC         (PC)
    ) u_vartheta (
        .x_i(vt_op),
        .y_o(vt_res)
    );

    // in_ready is masked by rst so it reads low during the reset cycle itself.
    assign in_ready  = in_ready_q & ~rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_block = {l_q, r_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        l_q        <= in_block[0 +: SIDE_SIZE];
                        r_q        <= in_block[SIDE_SIZE +: SIDE_SIZE];
                        cnt_q      <= in_iter;
                        in_ready_q <= 1'b0;
                        if (in_iter != '0) begin
                            state_q <= LEFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                LEFT: begin
                    l_q     <= vt_res;
                    state_q <= RIGHT;
                end
                RIGHT: begin
                    r_q   <= vt_res;
                    cnt_q <= cnt_d;
                    if (cnt_q == ITER_W'(1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= LEFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vartheta_seq_ctrl.sv
// Directed bench for vartheta_seq_ctrl: reset, pass counts 0/1/2/15, backpressure,
// reset abort mid-run.

module tb_vartheta_seq_ctrl;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [3:0]   in_iter;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    int n_checks;
    int n_fail;

    vartheta_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_block (in_block),
        .in_iter  (in_iter),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_block(out_block),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent model: each column rotated one bit at a time.
    function automatic logic [63:0] ref_vt(input logic [63:0] x);
        logic [15:0] c0, c1, c2;
        c0 = x[63:48];
        c1 = x[47:32];
        c2 = x[31:16];
        for (int k = 0; k < 13; k++) c0 = {c0[0], c0[15:1]};
        for (int k = 0; k < 3; k++)  c1 = {c1[0], c1[15:1]};
        c2 = {c2[0], c2[15:1]};
        return {c0, c1, c2, x[15:0]};
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] b, input int n);
        logic [63:0] l, r;
        l = b[127:64];
        r = b[63:0];
        for (int i = 0; i < n; i++) begin
            l = ref_vt(l);
            r = ref_vt(r);
        end
        return {l, r};
    endfunction

    // Presents a block, waits for acceptance, then counts edges until out_valid.
    task automatic run_block(input logic [127:0] blk, input logic [3:0] n,
                             output logic [127:0] res, output int lat);
        int w;
        in_block = blk;
        in_iter  = n;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        in_block = ~blk;
        in_iter  = ~n;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = out_block;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_block = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        in_iter  = 4'd3;
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready c%0d: got %b expected 0", c, in_ready); end
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid c%0d: got %b expected 0", c, out_valid); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c%0d: got %b expected 0", c, busy); end
            n_checks++;
            if (out_block !== 128'h0) begin n_fail++; $display("FAIL reset_out_block c%0d: got %h expected 0", c, out_block); end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got out_valid=%b busy=%b expected 0/0", out_valid, busy); end
    endtask

    task automatic test_n1();
        logic [127:0] res;
        int lat;
        out_ready = 1'b1;
        run_block({64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001}, 4'd1, res, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL n1_latency: got %0d expected 2", lat); end
        n_checks++;
        if (res !== {64'h0008_2000_8000_0001, 64'h0008_2000_8000_0001}) begin
            n_fail++; $display("FAIL n1_result: got %h expected %h", res, {64'h0008_2000_8000_0001, 64'h0008_2000_8000_0001});
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL n1_return_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_n2();
        logic [127:0] res;
        int lat;
        out_ready = 1'b1;
        run_block({64'h8000_8000_8000_8000, 64'h0}, 4'd2, res, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL n2_latency: got %0d expected 4", lat); end
        n_checks++;
        if (res !== {64'h0020_0200_2000_8000, 64'h0}) begin
            n_fail++; $display("FAIL n2_result: got %h expected %h", res, {64'h0020_0200_2000_8000, 64'h0});
        end
        tick();
    endtask

    task automatic test_n0();
        logic [127:0] res;
        int lat;
        out_ready = 1'b1;
        run_block(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 4'd0, res, lat);
        n_checks++;
        if (lat !== 0) begin n_fail++; $display("FAIL n0_latency: got %0d expected 0", lat); end
        n_checks++;
        if (res !== 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D) begin
            n_fail++; $display("FAIL n0_result: got %h expected %h", res, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] res;
        logic [127:0] exp1;
        int lat;
        exp1 = {64'h0008_2000_8000_0001, 64'h0004_1000_4000_8000};
        out_ready = 1'b0;
        run_block({64'h0001_0001_0001_0001, 64'h8000_8000_8000_8000}, 4'd1, res, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d expected 2", lat); end
        // Second block waits on the input while the first is held.
        in_block = {64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001};
        in_iter  = 4'd1;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_block !== exp1) begin
                n_fail++; $display("FAIL bp_hold c%0d: got valid=%b block=%h expected 1 %h", c, out_valid, out_block, exp1);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== 2 || out_block !== {64'h0008_2000_8000_0001, 64'h0008_2000_8000_0001}) begin
            n_fail++; $display("FAIL bp_second_result: got lat=%0d block=%h expected 2 %h", lat, out_block, {64'h0008_2000_8000_0001, 64'h0008_2000_8000_0001});
        end
        tick();
    endtask

    task automatic test_reset_abort_and_max();
        logic [127:0] res;
        logic [127:0] blk;
        int lat;
        int seen;
        out_ready = 1'b1;
        in_block  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        in_iter   = 4'd3;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_idle: got busy=%b out_valid=%b in_ready=%b expected 0/0/1", busy, out_valid, in_ready);
        end
        n_checks++;
        if (out_block !== 128'h0) begin n_fail++; $display("FAIL abort_block: got %h expected 0", out_block); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses expected 0", seen); end
        blk = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        run_block(blk, 4'd15, res, lat);
        n_checks++;
        if (lat !== 30) begin n_fail++; $display("FAIL max_latency: got %0d expected 30", lat); end
        n_checks++;
        if (res !== ref_block(blk, 15)) begin n_fail++; $display("FAIL max_result: got %h expected %h", res, ref_block(blk, 15)); end
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        in_iter   = '0;
        out_ready = 1'b0;
        test_reset();
        test_n1();
        test_n2();
        test_n0();
        test_back_to_back();
        test_reset_abort_and_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
